// File: rtl/dpot_multi_spi_pkg.sv
// Shared constants for the multi-channel digital-pot SPI driver.
//  - FSM state encodings (IDLE..GAP)
//  - SPI mode constant: CPOL=0, so SCLK idles low
package dpot_multi_spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  // SCLK idle level.
  localparam logic SPI_CPOL = 1'b0;

endpackage

// File: rtl/dpot_multi_spi_sclk_gen.sv
// SCLK generator: divides clk into SCLK half-periods of CLK_DIV clocks.
// Ports:
//  clk, rst      system clock, async active-low reset
//  i_en          count half-periods (held at 0 when low)
//  i_shift       let SCLK toggle at each half-period end; otherwise SCLK idles
//  o_tick_c      comb: last clk of the current half-period
//  o_fall_c      comb: SCLK falls on the coming edge
//  o_sclk        registered SCLK level
module dpot_multi_spi_sclk_gen
  import dpot_multi_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_shift,
  output logic o_tick_c,
  output logic o_fall_c,
  output logic o_sclk
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;

  assign o_tick_c = i_en && (r_cnt == CNT_W'(CLK_DIV - 1));
  assign o_fall_c = o_tick_c && i_shift && (r_sclk != SPI_CPOL);
  assign o_sclk   = r_sclk;

  // Half-period counter and SCLK level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_sclk <= SPI_CPOL;
    end else begin
      r_cnt  <= (!i_en || o_tick_c) ? '0 : r_cnt + CNT_W'(1);
      r_sclk <= i_shift ? (r_sclk ^ o_tick_c) : SPI_CPOL;
    end
  end

endmodule

// File: rtl/dpot_multi_spi.sv
// Multi-channel AD5160-class digital pot driver on a shared SCLK/MOSI bus.
// Each channel gets its own frame with its own nCS; the lowest pending channel goes first.
// Ports:
//  clk, rst    system clock, async active-low reset
//  value       CHANNELS wiper codes, channel i = value[i*DATA_W +: DATA_W]
//  update      request a send of every channel
//  auto_mode   request a send of any channel whose value differs from the last one sent
//  ready       idle with nothing pending
//  active_ch   channel of the current or most recent frame
//  nCS         per-channel chip select, active low
//  SCLK, MOSI  SPI mode 0 bus, MSB first
module dpot_multi_spi
  import dpot_multi_spi_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned GAP_CYC  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*DATA_W-1:0]   value,
  input  logic                         update,
  input  logic                         auto_mode,
  output logic                         ready,
  output logic [$clog2(CHANNELS):0]    active_ch,
  output logic [CHANNELS-1:0]          nCS,
  output logic                         SCLK,
  output logic                         MOSI
);

  localparam int unsigned CH_W   = $clog2(CHANNELS) + 1;
  localparam int unsigned HALF_W = $clog2(2 * DATA_W + GAP_CYC) + 1;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [CHANNELS-1:0] r_pend;
  logic [DATA_W-1:0]   r_sent [CHANNELS];
  logic [DATA_W-1:0]   r_shift;
  logic [CH_W-1:0]     r_ch;
  logic [CHANNELS-1:0] r_ncs;
  logic                r_mosi;
  logic                r_ready;
  logic [HALF_W-1:0]   r_half;

  logic [CH_W-1:0]     w_sel;
  logic [CHANNELS-1:0] w_onehot;
  logic [DATA_W-1:0]   w_sel_val;
  logic                w_any;
  logic                w_load;
  logic [CHANNELS-1:0] w_set;
  logic [CHANNELS-1:0] w_clr;
  logic [DATA_W-1:0]   w_shl;
  logic                w_tick;
  logic                w_fall;
  logic                w_sclk;
  logic                w_gen_en;
  logic                w_gen_shift;

  assign w_any       = |r_pend;
  assign w_load      = (w_state_nxt == ST_LOAD);
  assign w_clr       = w_load ? w_onehot : '0;
  assign w_shl       = r_shift << 1;
  assign w_gen_en    = (r_state == ST_SETUP) || (r_state == ST_SHIFT) ||
                       (r_state == ST_HOLD)  || (r_state == ST_GAP);
  assign w_gen_shift = (r_state == ST_SHIFT);

  dpot_multi_spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_gen_en),
    .i_shift  (w_gen_shift),
    .o_tick_c (w_tick),
    .o_fall_c (w_fall),
    .o_sclk   (w_sclk)
  );

  // Fixed-priority encoder: lowest pending index wins (descending loop, last hit kept)
  always_comb begin
    w_sel     = '0;
    w_onehot  = '0;
    w_sel_val = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel       = CH_W'(i);
        w_onehot    = '0;
        w_onehot[i] = 1'b1;
        w_sel_val   = value[i*DATA_W +: DATA_W];
      end
    end
  end

  // Requests; the channel being loaded compares against the value it is about to send
  always_comb begin
    w_set = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      w_set[i] = update ||
                 (auto_mode && (value[i*DATA_W +: DATA_W] != r_sent[i]) &&
                  !(w_load && w_onehot[i]));
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_SETUP;
      ST_SETUP: if (w_tick) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_tick && (r_half == HALF_W'(2 * DATA_W - 1))) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_tick) w_state_nxt = ST_GAP;
      ST_GAP:   if (w_tick && (r_half == HALF_W'(GAP_CYC - 1)))
                  w_state_nxt = w_any ? ST_LOAD : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Pending mask, shadow registers, shifter and registered pin outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend  <= '0;
      r_shift <= '0;
      r_ch    <= '0;
      r_ncs   <= '1;
      r_mosi  <= 1'b0;
      r_ready <= 1'b1;
      r_half  <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) r_sent[i] <= '0;
    end else begin
      r_pend  <= (r_pend & ~w_clr) | w_set;
      r_ready <= (r_state == ST_IDLE) && !w_any;

      // Half-period count within SHIFT/GAP; restarts on every state change
      if (w_state_nxt != r_state) r_half <= '0;
      else if (w_tick)            r_half <= r_half + HALF_W'(1);

      if (w_load) begin
        r_ch    <= w_sel;
        r_shift <= w_sel_val;
        r_mosi  <= w_sel_val[DATA_W-1];
        r_ncs   <= ~w_onehot;
        for (int i = 0; i < int'(CHANNELS); i++)
          if (w_onehot[i]) r_sent[i] <= w_sel_val;
      end else if (w_fall) begin
        // Last fall shifts out zeros, so MOSI is low for HOLD and GAP
        r_shift <= w_shl;
        r_mosi  <= w_shl[DATA_W-1];
      end else if ((r_state == ST_HOLD) && w_tick) begin
        r_ncs  <= '1;
        r_mosi <= 1'b0;
      end
    end
  end

  assign ready     = r_ready;
  assign active_ch = r_ch;
  assign nCS       = r_ncs;
  assign SCLK      = w_sclk;
  assign MOSI      = r_mosi;

endmodule
